// File: rtl/ccd_i2c_config_sequencer.sv
// CCD sensor I2C register-table writer: boot table, exposure key, zoom switch.
// Optional NACK retry/oERR logic is enabled by CCD_I2C_NACK_RETRY_EN.
module ccd_i2c_config_sequencer #(
  parameter int          CLK_FREQ      = 50_000_000,
  parameter int          I2C_FREQ      = 20_000,
  parameter logic [7:0]  DEV_ADDR      = 8'hBA,
  parameter int          STARTUP_DLY   = 50_000,
  parameter logic [15:0] EXPOSURE_INIT = 16'h0500,
  parameter logic [15:0] EXPOSURE_STEP = 16'h0200,
  parameter int          MAX_RETRY     = 3
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iEXPOSURE_ADJ,
  input  logic        iEXPOSURE_DEC_p,
  input  logic        iZOOM_MODE_SW,
  output logic        oI2C_SCLK,
  inout  wire         ioI2C_SDAT,
  output logic        oBUSY,
  output logic        oCONFIG_DONE,
  output logic        oERR,
  output logic [15:0] oEXPOSURE
);

  localparam int TDIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int DW   = $clog2(TDIV + 1);
  localparam int WW   = $clog2(STARTUP_DLY + 1);

  typedef enum logic [2:0] {
    S_WAIT, S_IDLE, S_LOAD, S_START,
    S_BIT, S_ACK, S_STOP, S_GAP
  } state_t;

  state_t        r_state, w_nxt;
  logic          r_run;
  logic [2:0]    r_es, r_zs, r_ok;
  logic [WW-1:0] r_wcnt;
  logic [DW-1:0] r_div;
  logic [1:0]    r_ph;
  logic [4:0]    r_bit;
  logic [31:0]   r_sr;
  logic [2:0]    r_idx;
  logic          r_full, r_pend_full, r_pend_exp;
  logic          r_done, r_nack;
  logic [15:0]   r_exp;

  logic          w_bus, w_tick, w_pe, w_last;
  logic          w_abort, w_retry;
  logic          w_exp_ev, w_zoom_ev;
  logic [16:0]   w_sum, w_dif;
  logic [15:0]   w_exp_nxt;
  logic [23:0]   w_entry;
  logic          w_scl, w_sda_low;

  assign w_bus  = r_state inside {S_START, S_BIT, S_ACK, S_STOP, S_GAP};
  assign w_tick = w_bus && (r_div == DW'(TDIV - 1));
  assign w_pe   = w_tick && (r_ph == 2'd3);
  assign w_last = (r_idx == 3'd7) || !r_full;

  // Zoom compare is held off until the synchroniser holds real samples.
  assign w_exp_ev  = r_es[2] & ~r_es[1];
  assign w_zoom_ev = r_ok[2] & (r_zs[1] ^ r_zs[2]);

  assign w_sum = {1'b0, r_exp} + {1'b0, EXPOSURE_STEP};
  assign w_dif = {1'b0, r_exp} - {1'b0, EXPOSURE_STEP};

  always_comb begin
    w_exp_nxt = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    if (iEXPOSURE_DEC_p)
      w_exp_nxt = (w_dif[16] || w_dif[15:0] == 16'h0)
                  ? 16'h0001 : w_dif[15:0];
  end

  always_comb begin
    w_entry = {8'h35, 16'h0018};
    case (r_idx)
      3'd0: w_entry = {8'h09, r_exp};
      3'd1: w_entry = {8'h01, 16'h0036};
      3'd2: w_entry = {8'h02, 16'h0010};
      3'd3: w_entry = {8'h03, r_zs[1] ? 16'h03BF : 16'h077F};
      3'd4: w_entry = {8'h04, r_zs[1] ? 16'h04FF : 16'h09FF};
      3'd5: w_entry = {8'h22, r_zs[1] ? 16'h0000 : 16'h0011};
      3'd6: w_entry = {8'h23, r_zs[1] ? 16'h0000 : 16'h0011};
      default: w_entry = {8'h35, 16'h0018};
    endcase
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_WAIT:  if (r_wcnt == WW'(STARTUP_DLY - 1)) w_nxt = S_LOAD;
      S_IDLE:  if (r_pend_full | r_pend_exp) w_nxt = S_LOAD;
      S_LOAD:  w_nxt = S_START;
      S_START: if (w_pe) w_nxt = S_BIT;
      S_BIT:   if (w_pe) w_nxt = (r_bit[2:0] == 3'd7) ? S_ACK : S_BIT;
      S_ACK:   if (w_pe) w_nxt = (r_bit == 5'd0 || w_abort) ? S_STOP : S_BIT;
      S_STOP:  if (w_pe) w_nxt = S_GAP;
      S_GAP:   if (w_pe) w_nxt = (w_retry || !w_last) ? S_LOAD : S_IDLE;
      default: w_nxt = S_WAIT;
    endcase
  end

  // SCL is high in ticks 1-2 of every bit; SDA only moves in tick 0.
  always_comb begin
    w_scl     = 1'b1;
    w_sda_low = 1'b0;
    unique case (r_state)
      S_START: begin w_scl = ~r_ph[1]; w_sda_low = 1'b1; end
      S_BIT:   begin w_scl = r_ph[0] ^ r_ph[1]; w_sda_low = ~r_sr[31]; end
      S_ACK:   w_scl = r_ph[0] ^ r_ph[1];
      S_STOP:  begin w_scl = (r_ph != 2'd0); w_sda_low = ~r_ph[1]; end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= S_WAIT;
      r_run       <= 1'b0;
      r_es        <= 3'b111;
      r_zs        <= 3'b000;
      r_ok        <= 3'b000;
      r_wcnt      <= '0;
      r_div       <= '0;
      r_ph        <= 2'd0;
      r_bit       <= 5'd0;
      r_sr        <= 32'h0;
      r_idx       <= 3'd0;
      r_full      <= 1'b0;
      r_pend_full <= 1'b0;
      r_pend_exp  <= 1'b0;
      r_done      <= 1'b0;
      r_nack      <= 1'b0;
      r_exp       <= EXPOSURE_INIT;
    end else begin
      r_state <= w_nxt;
      r_run   <= 1'b1;
      r_es    <= {r_es[1:0], iEXPOSURE_ADJ};
      r_zs    <= {r_zs[1:0], iZOOM_MODE_SW};
      r_ok    <= {r_ok[1:0], 1'b1};
      r_div   <= (w_bus && !w_tick) ? r_div + 1'b1 : '0;
      r_ph    <= !w_bus ? 2'd0 : (w_tick ? r_ph + 2'd1 : r_ph);
      if (r_state == S_WAIT) begin
        r_wcnt <= r_wcnt + 1'b1;
        if (w_nxt == S_LOAD) begin
          r_full <= 1'b1;
          r_idx  <= 3'd0;
        end
      end
      // Requests are only consumed when launched from IDLE.
      if (r_state == S_IDLE && w_nxt == S_LOAD) begin
        r_full      <= r_pend_full;
        r_idx       <= 3'd0;
        r_pend_full <= 1'b0;
        r_pend_exp  <= 1'b0;
      end
      if (w_exp_ev) begin
        r_exp      <= w_exp_nxt;
        r_pend_exp <= 1'b1;
      end
      if (w_zoom_ev) r_pend_full <= 1'b1;
      if (r_state == S_LOAD) begin
        r_sr   <= {DEV_ADDR, w_entry};
        r_bit  <= 5'd0;
        r_nack <= 1'b0;
      end
      if (r_state == S_BIT && w_pe) begin
        r_sr  <= {r_sr[30:0], 1'b0};
        r_bit <= r_bit + 5'd1;
      end
      if (r_state == S_ACK && w_tick && r_ph == 2'd1)
        r_nack <= ioI2C_SDAT;
      if (r_state == S_GAP && w_pe && !w_retry) begin
        if (!w_last) r_idx <= r_idx + 3'd1;
        else if (r_full) r_done <= 1'b1;
      end
    end
  end

`ifdef CCD_I2C_NACK_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] r_retry;
  logic          r_err;

  assign w_abort = r_nack;
  assign w_retry = r_nack && (r_retry < RW'(MAX_RETRY));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_retry <= '0;
      r_err   <= 1'b0;
    end else if (r_state == S_GAP && w_pe) begin
      if (w_retry) begin
        r_retry <= r_retry + 1'b1;
      end else begin
        r_retry <= '0;
        if (r_nack) r_err <= 1'b1;
      end
    end
  end

  assign oERR = r_err;
`else
  logic w_unused_nack;
  assign w_abort       = 1'b0;
  assign w_retry       = 1'b0;
  assign w_unused_nack = r_nack ^ MAX_RETRY[0];
  assign oERR          = 1'b0;
`endif

  assign oI2C_SCLK    = w_scl;
  assign ioI2C_SDAT   = w_sda_low ? 1'b0 : 1'bz;
  assign oBUSY        = r_run & ((r_state != S_IDLE) | r_pend_full | r_pend_exp);
  assign oCONFIG_DONE = r_done;
  assign oEXPOSURE    = r_exp;

endmodule
